// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU/shifter: operation codes and FSM states.
package seq_alu_pkg;

    typedef enum logic [2:0] {
        NOP  = 3'd0,
        LOAD = 3'd1,
        ADD  = 3'd2,
        SUB  = 3'd3,
        ROL  = 3'd4,
        ROR  = 3'd5,
        SHL  = 3'd6,
        ASR  = 3'd7
    } op_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic logic is_shift(op_t op);
        return op inside {ROL, ROR, SHL, ASR};
    endfunction

endpackage

// File: rtl/seq_alu_step.sv
// Combinational single-bit step of the result register for the shift/rotate ops.
module seq_alu_step
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_value,
    input  op_t              i_op,
    output logic [WIDTH-1:0] o_value,
    output logic             o_bit
);

    always_comb begin
        o_value = i_value;
        o_bit   = 1'b0;
        case (i_op)
            ROL: begin
                o_value = {i_value[WIDTH-2:0], i_value[WIDTH-1]};
                o_bit   = i_value[WIDTH-1];
            end
            ROR: begin
                o_value = {i_value[0], i_value[WIDTH-1:1]};
                o_bit   = i_value[0];
            end
            SHL: begin
                o_value = {i_value[WIDTH-2:0], 1'b0};
                o_bit   = i_value[WIDTH-1];
            end
            ASR: begin
                o_value = {i_value[WIDTH-1], i_value[WIDTH-1:1]};
                o_bit   = i_value[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/seq_alu_shifter.sv
// WIDTH-bit result register with single-cycle LOAD/ADD/SUB, bit-serial shifts and
// a Start/Busy/Done handshake; Carry/Zero/Overflow are registered with the result.
module seq_alu_shifter
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [WIDTH-1:0]   Input_1,
    input  logic [WIDTH-1:0]   Input_2,
    input  logic [2:0]         Op,
    input  logic [SHAMT_W-1:0] Amount,
    input  logic               Start,
    output logic [WIDTH-1:0]   Output,
    output logic               Carry,
    output logic               Zero,
    output logic               Overflow,
    output logic               Busy,
    output logic               Done
);

    state_t               r_state, w_state_next;
    op_t                  r_op, w_op_next;
    logic [SHAMT_W-1:0]   r_count, w_count_next;
    logic [WIDTH-1:0]     r_out, w_out_next;
    logic                 r_carry, w_carry_next;
    logic                 r_zero, w_zero_next;
    logic                 r_ovf, w_ovf_next;
    logic                 r_busy, w_busy_next;
    logic                 r_done, w_done_next;
    logic                 w_write;

    op_t                  w_op_in;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_diff;
    logic [WIDTH-1:0]     w_step_value;
    logic                 w_step_bit;

    assign w_op_in = op_t'(Op);
    assign w_sum   = {1'b0, Input_1} + {1'b0, Input_2};
    // Top bit of the extended difference is the unsigned borrow.
    assign w_diff  = {1'b0, Input_1} - {1'b0, Input_2};

    seq_alu_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_value (r_out),
        .i_op    (r_op),
        .o_value (w_step_value),
        .o_bit   (w_step_bit)
    );

    always_comb begin
        w_state_next = r_state;
        w_op_next    = r_op;
        w_count_next = r_count;
        w_out_next   = r_out;
        w_carry_next = r_carry;
        w_ovf_next   = r_ovf;
        w_busy_next  = r_busy;
        w_done_next  = 1'b0;
        w_write      = 1'b0;

        case (r_state)
            IDLE: begin
                if (Start) begin
                    case (w_op_in)
                        LOAD: begin
                            w_out_next   = Input_1;
                            w_carry_next = 1'b0;
                            w_ovf_next   = 1'b0;
                            w_write      = 1'b1;
                            w_done_next  = 1'b1;
                        end
                        ADD: begin
                            w_out_next   = w_sum[WIDTH-1:0];
                            w_carry_next = w_sum[WIDTH];
                            w_ovf_next   = (Input_1[WIDTH-1] == Input_2[WIDTH-1]) &&
                                           (w_sum[WIDTH-1] != Input_1[WIDTH-1]);
                            w_write      = 1'b1;
                            w_done_next  = 1'b1;
                        end
                        SUB: begin
                            w_out_next   = w_diff[WIDTH-1:0];
                            w_carry_next = w_diff[WIDTH];
                            w_ovf_next   = (Input_1[WIDTH-1] != Input_2[WIDTH-1]) &&
                                           (w_diff[WIDTH-1] != Input_1[WIDTH-1]);
                            w_write      = 1'b1;
                            w_done_next  = 1'b1;
                        end
                        default: begin
                            if (is_shift(w_op_in)) begin
                                if (Amount == '0) begin
                                    w_done_next = 1'b1;
                                end else begin
                                    w_state_next = SHIFT;
                                    w_op_next    = w_op_in;
                                    w_count_next = Amount;
                                    w_busy_next  = 1'b1;
                                end
                            end
                        end
                    endcase
                end
            end
            SHIFT: begin
                w_out_next   = w_step_value;
                w_carry_next = w_step_bit;
                w_ovf_next   = 1'b0;
                w_write      = 1'b1;
                w_count_next = r_count - SHAMT_W'(1);
                if (r_count == SHAMT_W'(1)) begin
                    w_state_next = IDLE;
                    w_busy_next  = 1'b0;
                    w_done_next  = 1'b1;
                end
            end
            default: ;
        endcase

        w_zero_next = w_write ? (w_out_next == '0) : r_zero;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_op    <= NOP;
            r_count <= '0;
            r_out   <= '0;
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_op    <= w_op_next;
            r_count <= w_count_next;
            r_out   <= w_out_next;
            r_carry <= w_carry_next;
            r_zero  <= w_zero_next;
            r_ovf   <= w_ovf_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
        end
    end

    assign Output   = r_out;
    assign Carry    = r_carry;
    assign Zero     = r_zero;
    assign Overflow = r_ovf;
    assign Busy     = r_busy;
    assign Done     = r_done;

endmodule

// File: tb/tb_seq_alu_shifter.sv
// Self-checking bench for seq_alu_shifter (WIDTH=8): directed scenarios plus randomized
// operations compared against an arithmetic reference model.
module tb_seq_alu_shifter;
    import seq_alu_pkg::*;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] Input_1, Input_2;
    logic [2:0] Op;
    logic [2:0] Amount;
    logic       Start;
    logic [7:0] Output;
    logic       Carry, Zero, Overflow, Busy, Done;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] m_out;
    logic       m_c, m_z, m_v;
    logic [7:0] trace [0:63];

    always #5 CLK = ~CLK;

    seq_alu_shifter #(.WIDTH(8)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .Input_1  (Input_1),
        .Input_2  (Input_2),
        .Op       (Op),
        .Amount   (Amount),
        .Start    (Start),
        .Output   (Output),
        .Carry    (Carry),
        .Zero     (Zero),
        .Overflow (Overflow),
        .Busy     (Busy),
        .Done     (Done)
    );

    // Reference model: whole-operation result computed arithmetically.
    task automatic model_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                            input int n);
        int x, sx, sa, sb, r;
        x  = int'(m_out);
        sx = int'($signed(m_out));
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (op)
            LOAD: begin m_out = a; m_c = 1'b0; m_v = 1'b0; m_z = (a == 0); end
            ADD: begin
                r = int'(a) + int'(b);
                m_out = 8'(r); m_c = (r > 255);
                m_v = (sa + sb > 127) || (sa + sb < -128); m_z = (m_out == 0);
            end
            SUB: begin
                r = int'(a) - int'(b);
                m_out = 8'(r); m_c = (a < b);
                m_v = (sa - sb > 127) || (sa - sb < -128); m_z = (m_out == 0);
            end
            ROL, ROR, SHL, ASR: begin
                if (n > 0) begin
                    case (op)
                        ROL: begin r = (x << n) | (x >> (8 - n)); m_c = 1'((x >> (8 - n)) & 1); end
                        ROR: begin r = (x >> n) | (x << (8 - n)); m_c = 1'((x >> (n - 1)) & 1); end
                        SHL: begin r = x << n; m_c = 1'((x >> (8 - n)) & 1); end
                        default: begin r = sx >>> n; m_c = 1'((x >> (n - 1)) & 1); end
                    endcase
                    m_out = 8'(r); m_v = 1'b0; m_z = (m_out == 0);
                end
            end
            default: ;
        endcase
    endtask

    // Drives one request from a negedge and watches until one cycle past Done (bounded).
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] amt, output int lat, output int ndone,
                         output int nbusy);
        Op = op; Input_1 = a; Input_2 = b; Amount = amt; Start = 1'b1;
        lat = -1; ndone = 0; nbusy = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge CLK);
            if (k == 1) Start = 1'b0;
            trace[k] = Output;
            if (Busy) nbusy++;
            if (Done) begin
                ndone++;
                if (lat < 0) lat = k;
            end
            if (lat >= 0 && k >= lat + 1) break;
        end
    endtask

    function automatic logic [34:0] obs(int lat, int nd, int nb);
        return {8'(lat), 8'(nd), 8'(nb), Output, Carry, Zero, Overflow};
    endfunction

    function automatic logic [34:0] expv(int lat, int nb, logic [7:0] o, logic c, logic z,
                                         logic v);
        return {8'(lat), 8'd1, 8'(nb), o, c, z, v};
    endfunction

    task automatic test_reset();
        RST = 1'b1; Start = 1'b0; Op = 3'd0; Amount = 3'd0; Input_1 = 8'h00; Input_2 = 8'h00;
        repeat (2) @(negedge CLK);
        n_checks++;
        if ({Output, Carry, Zero, Overflow, Busy, Done} !== 13'd0) begin
            n_errors++;
            $display("FAIL reset: got %h required 0", {Output, Carry, Zero, Overflow, Busy, Done});
        end
        RST = 1'b0;
        m_out = 8'h00; m_c = 1'b0; m_z = 1'b0; m_v = 1'b0;
    endtask

    task automatic test_add_sub();
        int lat, nd, nb;
        issue(ADD, 8'h80, 8'h80, 3'd0, lat, nd, nb); model_op(ADD, 8'h80, 8'h80, 0);
        n_checks++;
        if (obs(lat, nd, nb) !== expv(1, 0, 8'h00, 1, 1, 1)) begin
            n_errors++;
            $display("FAIL add_80_80: got %h required %h", obs(lat, nd, nb), expv(1, 0, 8'h00, 1, 1, 1));
        end
        issue(SUB, 8'h80, 8'h01, 3'd0, lat, nd, nb); model_op(SUB, 8'h80, 8'h01, 0);
        n_checks++;
        if (obs(lat, nd, nb) !== expv(1, 0, 8'h7F, 0, 0, 1)) begin
            n_errors++;
            $display("FAIL sub_80_01: got %h required %h", obs(lat, nd, nb), expv(1, 0, 8'h7F, 0, 0, 1));
        end
        issue(SUB, 8'h04, 8'h18, 3'd0, lat, nd, nb); model_op(SUB, 8'h04, 8'h18, 0);
        n_checks++;
        if (obs(lat, nd, nb) !== expv(1, 0, 8'hEC, 1, 0, 0)) begin
            n_errors++;
            $display("FAIL sub_04_18: got %h required %h", obs(lat, nd, nb), expv(1, 0, 8'hEC, 1, 0, 0));
        end
    endtask

    task automatic test_rol_steps();
        int lat, nd, nb;
        logic [7:0] exp_tr [1:4];
        exp_tr = '{8'h18, 8'h30, 8'h60, 8'hC0};
        issue(LOAD, 8'h18, 8'h00, 3'd0, lat, nd, nb); model_op(LOAD, 8'h18, 8'h00, 0);
        issue(ROL, 8'h00, 8'h00, 3'd3, lat, nd, nb); model_op(ROL, 8'h00, 8'h00, 3);
        n_checks++;
        if (obs(lat, nd, nb) !== expv(4, 3, 8'hC0, 0, 0, 0)) begin
            n_errors++;
            $display("FAIL rol3: got %h required %h", obs(lat, nd, nb), expv(4, 3, 8'hC0, 0, 0, 0));
        end
        for (int k = 1; k <= 4; k++) begin
            n_checks++;
            if (trace[k] !== exp_tr[k]) begin
                n_errors++;
                $display("FAIL rol3_step%0d: got %h required %h", k, trace[k], exp_tr[k]);
            end
        end
    endtask

    task automatic test_ror_asr_shl0();
        int lat, nd, nb;
        issue(LOAD, 8'h81, 8'h00, 3'd0, lat, nd, nb); model_op(LOAD, 8'h81, 8'h00, 0);
        issue(ROR, 8'h00, 8'h00, 3'd1, lat, nd, nb); model_op(ROR, 8'h00, 8'h00, 1);
        n_checks++;
        if (obs(lat, nd, nb) !== expv(2, 1, 8'hC0, 1, 0, 0)) begin
            n_errors++;
            $display("FAIL ror1: got %h required %h", obs(lat, nd, nb), expv(2, 1, 8'hC0, 1, 0, 0));
        end
        issue(ASR, 8'h00, 8'h00, 3'd7, lat, nd, nb); model_op(ASR, 8'h00, 8'h00, 7);
        n_checks++;
        if (obs(lat, nd, nb) !== expv(8, 7, 8'hFF, 1, 0, 0)) begin
            n_errors++;
            $display("FAIL asr7: got %h required %h", obs(lat, nd, nb), expv(8, 7, 8'hFF, 1, 0, 0));
        end
        issue(SHL, 8'h00, 8'h00, 3'd0, lat, nd, nb); model_op(SHL, 8'h00, 8'h00, 0);
        n_checks++;
        if (obs(lat, nd, nb) !== expv(1, 0, 8'hFF, 1, 0, 0)) begin
            n_errors++;
            $display("FAIL shl0: got %h required %h", obs(lat, nd, nb), expv(1, 0, 8'hFF, 1, 0, 0));
        end
    endtask

    task automatic test_nop();
        logic [7:0] held;
        held = m_out;
        Op = NOP; Input_1 = 8'h55; Input_2 = 8'h33; Amount = 3'd2; Start = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge CLK);
            Start = 1'b0;
            n_checks++;
            if ({Output, Busy, Done} !== {held, 2'b00}) begin
                n_errors++;
                $display("FAIL nop_cycle%0d: got %h required %h", k, {Output, Busy, Done}, {held, 2'b00});
            end
        end
    endtask

    // ADD held on Start throughout a ROL 5; it must only be taken on the Done cycle.
    task automatic test_back_to_back();
        int lat, nd, nb;
        logic [9:0] exp_s [1:8];
        issue(LOAD, 8'h01, 8'h00, 3'd0, lat, nd, nb); model_op(LOAD, 8'h01, 8'h00, 0);
        exp_s = '{{8'h01, 2'b10}, {8'h02, 2'b10}, {8'h04, 2'b10}, {8'h08, 2'b10},
                  {8'h10, 2'b10}, {8'h20, 2'b01}, {8'h33, 2'b01}, {8'h33, 2'b00}};
        Op = ROL; Amount = 3'd5; Start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge CLK);
            if (k == 1) begin Op = ADD; Input_1 = 8'h11; Input_2 = 8'h22; end
            if (k == 7) Start = 1'b0;
            n_checks++;
            if ({Output, Busy, Done} !== exp_s[k]) begin
                n_errors++;
                $display("FAIL held_start_cycle%0d: got %h required %h", k, {Output, Busy, Done}, exp_s[k]);
            end
        end
        model_op(ROL, 8'h00, 8'h00, 5); model_op(ADD, 8'h11, 8'h22, 0);
        n_checks++;
        if ({Carry, Zero, Overflow} !== {m_c, m_z, m_v}) begin
            n_errors++;
            $display("FAIL held_start_flags: got %b required %b", {Carry, Zero, Overflow}, {m_c, m_z, m_v});
        end
    endtask

    task automatic test_reset_mid_shift();
        int lat, nd, nb;
        issue(LOAD, 8'h96, 8'h00, 3'd0, lat, nd, nb); model_op(LOAD, 8'h96, 8'h00, 0);
        Op = ROR; Amount = 3'd6; Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        @(negedge CLK);
        n_checks++;
        if ({Output, Busy} !== {8'h4B, 1'b1}) begin
            n_errors++;
            $display("FAIL ror6_step1: got %h required %h", {Output, Busy}, {8'h4B, 1'b1});
        end
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        n_checks++;
        if ({Output, Carry, Zero, Overflow, Busy, Done} !== 13'd0) begin
            n_errors++;
            $display("FAIL abort_reset: got %h required 0", {Output, Carry, Zero, Overflow, Busy, Done});
        end
        m_out = 8'h00; m_c = 1'b0; m_z = 1'b0; m_v = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge CLK);
            n_checks++;
            if ({Output, Busy, Done} !== 10'd0) begin
                n_errors++;
                $display("FAIL after_abort_cycle%0d: got %h required 0", k, {Output, Busy, Done});
            end
        end
        issue(LOAD, 8'h5A, 8'h00, 3'd0, lat, nd, nb); model_op(LOAD, 8'h5A, 8'h00, 0);
        n_checks++;
        if (obs(lat, nd, nb) !== expv(1, 0, 8'h5A, 0, 0, 0)) begin
            n_errors++;
            $display("FAIL load_after_reset: got %h required %h", obs(lat, nd, nb), expv(1, 0, 8'h5A, 0, 0, 0));
        end
    endtask

    task automatic test_random();
        int lat, nd, nb, el, eb;
        logic [2:0] op, amt;
        logic [7:0] a, b;
        for (int i = 0; i < 60; i++) begin
            op  = 3'($urandom_range(1, 7));
            amt = 3'($urandom_range(0, 7));
            a   = 8'($urandom);
            b   = 8'($urandom);
            if (i % 5 == 0) b = a ^ 8'h80;
            eb  = (op >= 3'd4) ? int'(amt) : 0;
            el  = eb + 1;
            model_op(op, a, b, int'(amt));
            issue(op, a, b, amt, lat, nd, nb);
            n_checks++;
            if (obs(lat, nd, nb) !== expv(el, eb, m_out, m_c, m_z, m_v)) begin
                n_errors++;
                $display("FAIL random%0d op=%0d a=%h b=%h amt=%0d: got %h required %h", i, op, a, b,
                         amt, obs(lat, nd, nb), expv(el, eb, m_out, m_c, m_z, m_v));
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_rol_steps();
        test_ror_asr_shl0();
        test_nop();
        test_back_to_back();
        test_reset_mid_shift();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_alu_shifter.md
Name: seq_alu_shifter

Overview:
Parameterised successor to the 8-bit add/sub/rotate register: a WIDTH-bit result register with a Start/Busy/Done handshake. ADD, SUB and LOAD complete in one cycle. Rotates and shifts step the register one bit per cycle by a programmable amount. Status flags (Carry, Zero, Overflow) are registered alongside the result. It sits as a datapath slave under a small controller that issues one operation at a time.

Parameters:
- WIDTH, 8, datapath width in bits; must be at least 2.
- SHAMT_W, $clog2(WIDTH), width of the Amount port (derived, not overridden).

Ports:
- CLK, input, 1, single system clock; all state changes on the rising edge.
- RST, input, 1, synchronous active-high reset, sampled on the CLK rising edge.
- Input_1, input, WIDTH, operand A; also the load value.
- Input_2, input, WIDTH, operand B.
- Op, input, 3, operation code (see package).
- Amount, input, SHAMT_W, shift/rotate distance, range 0..WIDTH-1.
- Start, input, 1, request; accepted only when Busy=0.
- Output, output, WIDTH, result register.
- Carry, output, 1, carry/borrow/last bit out.
- Zero, output, 1, Output==0, registered.
- Overflow, output, 1, signed overflow of the last ADD or SUB.
- Busy, output, 1, a multi-cycle shift is in progress.
- Done, output, 1, one-cycle pulse marking operation complete.

Behaviour:
- Reset (synchronous, RST=1 at an edge): Output=0, Carry=0, Zero=0, Overflow=0, Busy=0, Done=0, state=IDLE, step counter=0. RST overrides Start and aborts any shift in progress with no Done pulse.
- FSM has two states: IDLE and SHIFT.
- Accept: on a rising edge in IDLE with Start=1, the block latches Op and Amount. Start while Busy=1 is ignored and not queued. Start with Op=NOP produces no register change and no Done.
- LOAD (single cycle): Output<=Input_1 on the accept edge; Carry=0, Overflow=0. Done=1 for exactly the next cycle.
- ADD (single cycle): {Carry,Output}<=Input_1+Input_2 (WIDTH+1-bit sum, wraps modulo 2^WIDTH). Overflow=1 when both operands have the same sign and the result sign differs. Done=1 for exactly the next cycle.
- SUB (single cycle): Output<=Input_1-Input_2 modulo 2^WIDTH. Carry=1 means borrow, i.e. Input_1<Input_2 unsigned. Overflow=1 when the operand signs differ and the result sign differs from Input_1. Done=1 for exactly the next cycle.
- Shift ops (ROL, ROR, SHL, ASR) operate on the current Output value; Input_1 and Input_2 are ignored.
  - Amount=n>0: the accept edge enters SHIFT, loads the counter with n and sets Busy=1; Output is unchanged on this edge. Each of the next n edges moves Output one bit and decrements the counter.
  - On the edge that applies the last step: Busy<=0, Done<=1, state returns to IDLE.
  - Total latency: accept edge plus n step edges; Done is visible in the cycle after step n.
  - Amount=0: no state change, no SHIFT entry, Output unchanged, Done pulses the cycle after accept, Carry is held.
- Per-step bit rules:
  - ROL: Output<={Output[W-2:0],Output[W-1]}; Carry=bit moved out (old MSB).
  - ROR: Output<={Output[0],Output[W-1:1]}; Carry=old LSB.
  - SHL: zero fill in the LSB; Carry=old MSB.
  - ASR: MSB replicated; Carry=old LSB.
  - Overflow is cleared on the first step.
- Zero is updated on every edge that writes Output, from the new value.
- Carry, Zero and Overflow hold their values when Output is not written.
- A new Start may be presented in the same cycle that Done=1; it is accepted, since Busy=0.

Decomposition:
- Package seq_alu_pkg holds op_t, an enum logic[2:0]: NOP=0, LOAD=1, ADD=2, SUB=3, ROL=4, ROR=5, SHL=6, ASR=7.
- The package also holds state_t: IDLE, SHIFT.
- One natural sub-module, seq_alu_step: a combinational one-bit step of the Output register for a given op_t, returning the next value and the bit out. It is instantiated once in the SHIFT datapath.
- The top level holds the FSM, the counter, the handshake and the flags.

Test Plan (WIDTH=8):
- ADD, Input_1=0x80, Input_2=0x80 -> Output=0x00, Carry=1, Zero=1, Overflow=1, Busy never high, Done single pulse.
- SUB, Input_1=0x80, Input_2=0x01 -> Output=0x7F, Carry=0, Overflow=1. Then SUB 0x04-0x18 -> Output=0xEC, Carry=1, Overflow=0.
- LOAD 0x18, then ROL Amount=3 -> Busy high for 3 cycles; intermediate values 0x30, 0x60, 0xC0; final 0xC0 with Carry=0; Done exactly 1 cycle after the last step.
- LOAD 0x81, then ROR Amount=1 -> 0xC0, Carry=1. Then ASR Amount=7 -> 0xFF, Zero=0. Then SHL Amount=0 -> 0xFF unchanged, Done next cycle, Busy never high.
- Start=1 with ADD held on every cycle during a ROL Amount=5 -> ignored, Output shows only the rotate; the ADD is accepted on the Done cycle.
- RST asserted at step 2 of ROR Amount=6 -> next edge Output=0, Busy=0, no Done. RST held for one cycle is sufficient, and a LOAD right after release works normally.
